// File: rtl/scoreboard_display.sv
// N-player front-panel scoreboard: latches scores and winners, runs the IDLE/SHOW/WIN
// phase FSM and drives active-low 7-segment digits plus player/busy LEDs.

module scoreboard_lane #(
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_dash,
  input  logic               i_win,
  input  logic               i_phase,
  output logic [13:0]        o_hex,
  output logic [1:0]         o_led
);
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [6:0] d);
    case (d)
      7'd0:    seg7 = 7'b0000001;
      7'd1:    seg7 = 7'b1001111;
      7'd2:    seg7 = 7'b0010010;
      7'd3:    seg7 = 7'b0000110;
      7'd4:    seg7 = 7'b1001100;
      7'd5:    seg7 = 7'b0100100;
      7'd6:    seg7 = 7'b0100000;
      7'd7:    seg7 = 7'b0001111;
      7'd8:    seg7 = 7'b0000000;
      7'd9:    seg7 = 7'b0000100;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [6:0]  w_val;
  logic [6:0]  w_sat;
  logic [6:0]  w_tens;
  logic [6:0]  w_units;
  logic [13:0] w_digits;

  // Two decimal digits only: anything past 99 pins at 99.
  always_comb begin
    w_val    = 7'(i_score);
    w_sat    = (w_val > 7'd99) ? 7'd99 : w_val;
    w_tens   = w_sat / 7'd10;
    w_units  = w_sat % 7'd10;
    w_digits = {seg7(w_tens), seg7(w_units)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_hex <= {SEG_BLANK, SEG_BLANK};
      o_led <= 2'b00;
    end else if (i_dash) begin
      o_hex <= {SEG_DASH, SEG_DASH};
      o_led <= 2'b00;
    end else begin
      o_hex <= (i_win && !i_phase) ? {SEG_BLANK, SEG_BLANK} : w_digits;
      o_led <= {2{i_win}};
    end
  end
endmodule

module scoreboard_display #(
  parameter int N_PLAYERS = 2,
  parameter int SCORE_W   = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   state_f,
  input  logic                         score_vld,
  input  logic [N_PLAYERS*SCORE_W-1:0] scores,
  input  logic [N_PLAYERS-1:0]         premio_f,
  output logic [N_PLAYERS*14-1:0]      hex,
  output logic [2*N_PLAYERS-1:0]       led_p,
  output logic                         led_busy
);
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHOW, WIN} state_t;

  state_t                             r_state, w_next;
  logic [N_PLAYERS-1:0]               r_mask, w_mask_nxt;
  logic [N_PLAYERS-1:0][SCORE_W-1:0]  r_score;
  logic [CNT_W-1:0]                   r_cnt;
  logic                               r_phase;
  logic                               r_busy;
  logic                               w_dash;
  logic [N_PLAYERS-1:0]               w_win;

  // state_f == 0 overrides everything; the winner mask is frozen once in WIN.
  always_comb begin
    w_next     = r_state;
    w_mask_nxt = r_mask;
    if (state_f == 4'd0) begin
      w_next     = IDLE;
      w_mask_nxt = '0;
    end else begin
      case (r_state)
        IDLE: w_next = SHOW;
        SHOW: if (|premio_f) begin
                w_next     = WIN;
                w_mask_nxt = premio_f;
              end
        WIN:  w_next = WIN;
        default: begin
          w_next     = IDLE;
          w_mask_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_score <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mask  <= w_mask_nxt;
      r_busy  <= (state_f != 4'd0);
      if (score_vld) r_score <= scores;
    end
  end

  // Blink timer only advances while staying in WIN, so every entry starts on a
  // full visible half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_state == WIN && w_next == WIN) begin
      if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end
  end

  assign w_dash = (r_state == IDLE);

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_lane
    assign w_win[g] = (r_state == WIN) && r_mask[g];

    scoreboard_lane #(.SCORE_W(SCORE_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_score (r_score[g]),
      .i_dash  (w_dash),
      .i_win   (w_win[g]),
      .i_phase (r_phase),
      .o_hex   (hex[g*14 +: 14]),
      .o_led   (led_p[2*g +: 2])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_busy <= 1'b0;
    else       led_busy <= r_busy;
  end
endmodule

// File: tb/tb_scoreboard_display.sv
// Scoreboard bench: stimulus queues cycle-tagged expected pin states, a negedge
// monitor pops and compares them against two DUTs (4-bit and 7-bit scores).

module tb_scoreboard_display;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S5 = 7'b0100100, S7 = 7'b0001111, S9 = 7'b0000100;
  localparam logic [6:0] DS = 7'b1111110, BL = 7'b1111111;
  localparam logic [27:0] BLANK4 = {BL, BL, BL, BL};
  localparam logic [27:0] DASH4  = {DS, DS, DS, DS};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  state_f = 4'd0;
  logic        score_vld = 1'b0;
  logic [7:0]  scores = 8'd0;
  logic [13:0] scores7 = 14'd0;
  logic [1:0]  premio_f = 2'b00;
  logic [27:0] hex, hex7;
  logic [3:0]  led_p, led_p7;
  logic        led_busy, led_busy7;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  scoreboard_display #(.N_PLAYERS(2), .SCORE_W(4), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .state_f(state_f), .score_vld(score_vld),
    .scores(scores), .premio_f(premio_f), .hex(hex), .led_p(led_p), .led_busy(led_busy)
  );

  scoreboard_display #(.N_PLAYERS(2), .SCORE_W(7), .BLINK_DIV(4)) dut7 (
    .clk(clk), .reset(reset), .state_f(state_f), .score_vld(score_vld),
    .scores(scores7), .premio_f(premio_f), .hex(hex7), .led_p(led_p7), .led_busy(led_busy7)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          which;
    string       name;
    logic [27:0] hex;
    logic [3:0]  led;
    logic        busy;
  } exp_t;

  exp_t q[$];

  task automatic expect_at(input int c, input int which, input string nm,
                           input logic [27:0] h, input logic [3:0] l, input logic b);
    exp_t e;
    e.cyc = c; e.which = which; e.name = nm; e.hex = h; e.led = l; e.busy = b;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  exp_t        m_e;
  logic [27:0] m_hex;
  logic [3:0]  m_led;
  logic        m_busy;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e    = q.pop_front();
      m_hex  = (m_e.which == 1) ? hex7 : hex;
      m_led  = (m_e.which == 1) ? led_p7 : led_p;
      m_busy = (m_e.which == 1) ? led_busy7 : led_busy;
      n_checks++;
      if (m_e.cyc != cyc || m_hex !== m_e.hex || m_led !== m_e.led || m_busy !== m_e.busy) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (due %0d): got hex=%b led=%b busy=%b, expected hex=%b led=%b busy=%b",
                 m_e.name, cyc, m_e.cyc, m_hex, m_led, m_busy, m_e.hex, m_e.led, m_e.busy);
      end
    end
  end

  initial begin
    int t0;
    logic [13:0] p1;

    repeat (2) tick();
    expect_at(cyc, 0, "reset_state", BLANK4, 4'b0000, 1'b0);
    tick();
    reset = 1'b0;
    expect_at(cyc + 2, 0, "idle_dash", DASH4, 4'b0000, 1'b0);
    repeat (2) tick();

    // Scores 12 / 7 with the 7-bit twin carrying 120 / 99.
    state_f = 4'd1; scores = {4'd12, 4'd7}; scores7 = {7'd120, 7'd99}; score_vld = 1'b1;
    t0 = cyc;
    expect_at(t0 + 2, 0, "show_12_7", {S1, S2, S0, S7}, 4'b0000, 1'b1);
    expect_at(t0 + 2, 1, "sat_120_99", {S9, S9, S9, S9}, 4'b0000, 1'b1);
    tick();
    score_vld = 1'b0;
    repeat (2) tick();

    // Player 1 wins: 4 shown, 4 blank, 4 shown; a late premio_f change is ignored.
    premio_f = 2'b10;
    t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      p1 = (((i / 4) % 2) == 0) ? {S1, S2} : {BL, BL};
      expect_at(t0 + 2 + i, 0, "blink_p1", {p1, S0, S7}, 4'b1100, 1'b1);
    end
    tick();
    premio_f = 2'b00;
    tick();
    premio_f = 2'b01;
    repeat (11) tick();
    premio_f = 2'b00;

    state_f = 4'd0;
    expect_at(cyc + 2, 0, "win_to_idle", DASH4, 4'b0000, 1'b0);
    repeat (3) tick();

    state_f = 4'd2;
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      expect_at(t0 + 2 + i, 0, "reshow_steady", {S1, S2, S0, S7}, 4'b0000, 1'b1);
    repeat (10) tick();

    // Tie with simultaneous score update: new scores blink together.
    scores = {4'd15, 4'd9}; scores7 = {7'd100, 7'd5}; score_vld = 1'b1; premio_f = 2'b11;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      expect_at(t0 + 2 + i, 0, "tie_blink", (i < 4) ? {S1, S5, S0, S9} : BLANK4, 4'b1111, 1'b1);
      if (i == 0) expect_at(t0 + 2, 1, "sat_100_5", {S9, S9, S0, S5}, 4'b1111, 1'b1);
    end
    tick();
    score_vld = 1'b0; premio_f = 2'b00;
    repeat (9) tick();

    // Digits are visible again here; asynchronous reset must blank them at once.
    reset = 1'b1;
    expect_at(cyc, 0, "reset_async", BLANK4, 4'b0000, 1'b0);
    expect_at(cyc, 1, "reset_async7", BLANK4, 4'b0000, 1'b0);
    state_f = 4'd0;
    repeat (2) tick();
    reset = 1'b0;
    expect_at(cyc + 2, 0, "post_reset_dash", DASH4, 4'b0000, 1'b0);
    repeat (4) tick();

    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover_expectations: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
